// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle.
// Groups every handshake and data signal between fetch_queue and its
// neighbours: the redirect request from execute/trap logic, the
// instruction-memory request/response channel and the decode-side
// valid/ready channel. Names keep the i_/o_ sense as seen from the fetch
// unit, so the slave modport is the fetch unit and the master modport is
// the environment around it.
//   i_redirect_valid/i_redirect_pc : redirect fetch to a new target
//   o_imem_req_*                   : request valid/addr, i_imem_req_ready accept
//   i_imem_resp_*                  : in-order, never-stalled responses
//   o_inst_valid/o_inst/o_pc       : {instruction, PC} to decode, i_inst_ready accept
//   o_fetch_fault/o_fault_pc       : misaligned redirect target pending
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_imem_req_valid;
    logic            i_imem_req_ready;
    logic [XLEN-1:0] o_imem_req_addr;
    logic            i_imem_resp_valid;
    logic [XLEN-1:0] i_imem_resp_data;
    logic            o_inst_valid;
    logic            i_inst_ready;
    logic [XLEN-1:0] o_inst;
    logic [XLEN-1:0] o_pc;
    logic            o_fetch_fault;
    logic [XLEN-1:0] o_fault_pc;

    modport master (
        output i_redirect_valid, i_redirect_pc, i_imem_req_ready,
               i_imem_resp_valid, i_imem_resp_data, i_inst_ready,
        input  o_imem_req_valid, o_imem_req_addr, o_inst_valid, o_inst,
               o_pc, o_fetch_fault, o_fault_pc
    );

    modport slave (
        input  i_redirect_valid, i_redirect_pc, i_imem_req_ready,
               i_imem_resp_valid, i_imem_resp_data, i_inst_ready,
        output o_imem_req_valid, o_imem_req_addr, o_inst_valid, o_inst,
               o_pc, o_fetch_fault, o_fault_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// RV32I fetch stage feeding decode.
// Issues sequential word requests to instruction memory, tracks the PC of
// every outstanding request, buffers in-order responses in a DEPTH-entry
// FIFO and presents {instruction, PC} to decode. A redirect flushes the FIFO
// and squashes every response still in flight; a misaligned redirect target
// parks the unit in a FAULT state until an aligned redirect arrives.
// Ports:
//   i_clk : system clock
//   rst   : asynchronous active-high reset
//   bus   : fetch_queue_if slave (redirect, imem request/response, decode)
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic          i_clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0]      ST_RUN   = 1'b0;
    localparam logic [0:0]      ST_FAULT = 1'b1;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [CW:0]     CREDITS  = (CW+1)'(DEPTH);

    logic [0:0]      state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] fault_pc_r;
    logic [CW-1:0]   occ_r;
    logic [CW-1:0]   outst_r;
    logic [CW-1:0]   drop_r;

    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   trk_wr_r;
    logic [AW-1:0]   trk_rd_r;
    logic [XLEN-1:0] fifo_inst_r [DEPTH];
    logic [XLEN-1:0] fifo_pc_r   [DEPTH];
    logic [XLEN-1:0] trk_pc_r    [DEPTH];

    logic            redirect_s;
    logic            aligned_s;
    logic            run_s;
    logic [CW:0]     inflight_s;
    logic            credit_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            resp_s;
    logic            drop_hit_s;
    logic            push_s;
    logic            inst_valid_s;
    logic            pop_s;
    logic [0:0]      state_n_s;

    assign redirect_s = bus.i_redirect_valid;
    assign aligned_s  = (bus.i_redirect_pc[1:0] == 2'b00);
    assign run_s      = (state_r == ST_RUN);

    // Buffered entries plus requests still in flight may never exceed DEPTH,
    // which is what keeps a response from ever finding the FIFO full.
    assign inflight_s = {1'b0, occ_r} + {1'b0, outst_r};
    assign credit_s   = (inflight_s < CREDITS);

    // rst gates the request combinationally so it drops the moment reset
    // asserts and the first request appears in the first cycle after release.
    assign req_valid_s = !rst && run_s && !redirect_s && credit_s;
    assign accept_s    = req_valid_s && bus.i_imem_req_ready;

    assign resp_s      = bus.i_imem_resp_valid;
    assign drop_hit_s  = resp_s && (drop_r != {CW{1'b0}});
    assign push_s      = resp_s && !drop_hit_s && !redirect_s;

    assign inst_valid_s = (occ_r != {CW{1'b0}}) && run_s;
    assign pop_s        = inst_valid_s && bus.i_inst_ready && !redirect_s;

    // Next fault/run state: only a redirect moves the state machine.
    always_comb begin
        state_n_s = state_r;
        if (redirect_s) begin
            state_n_s = aligned_s ? ST_RUN : ST_FAULT;
        end else begin
            state_n_s = state_r;
        end
    end

    // Control state: fetch PC, fault capture and the three credit counters.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            fetch_pc_r <= RESET_PC;
            fault_pc_r <= {XLEN{1'b0}};
            occ_r      <= {CW{1'b0}};
            outst_r    <= {CW{1'b0}};
            drop_r     <= {CW{1'b0}};
        end else begin
            state_r <= state_n_s;
            outst_r <= outst_r + CW'(accept_s) - CW'(resp_s);
            if (redirect_s) begin
                // Everything still in flight after this cycle is stale; a
                // response arriving now is consumed here, hence the minus one.
                drop_r <= outst_r - CW'(resp_s);
                occ_r  <= {CW{1'b0}};
                if (aligned_s) begin
                    fetch_pc_r <= bus.i_redirect_pc;
                end else begin
                    fault_pc_r <= bus.i_redirect_pc;
                end
            end else begin
                drop_r <= drop_r - CW'(drop_hit_s);
                occ_r  <= occ_r + CW'(push_s) - CW'(pop_s);
                if (accept_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end else begin
                    fetch_pc_r <= fetch_pc_r;
                end
            end
        end
    end

    // Pointers of the decode FIFO and of the outstanding-PC tracker. The
    // tracker is never flushed: squashed responses still retire its entries.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            trk_wr_r <= {AW{1'b0}};
            trk_rd_r <= {AW{1'b0}};
        end else begin
            if (redirect_s) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                wr_ptr_r <= wr_ptr_r + AW'(push_s);
                rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            end
            trk_wr_r <= trk_wr_r + AW'(accept_s);
            trk_rd_r <= trk_rd_r + AW'(resp_s);
        end
    end

    // Storage arrays; contents are only visible through valid-gated outputs.
    always_ff @(posedge i_clk) begin
        if (accept_s) begin
            trk_pc_r[trk_wr_r] <= fetch_pc_r;
        end
        if (push_s) begin
            fifo_inst_r[wr_ptr_r] <= bus.i_imem_resp_data;
            fifo_pc_r[wr_ptr_r]   <= trk_pc_r[trk_rd_r];
        end
    end

    assign bus.o_imem_req_valid = req_valid_s;
    assign bus.o_imem_req_addr  = fetch_pc_r;
    assign bus.o_inst_valid     = inst_valid_s;
    assign bus.o_inst           = inst_valid_s ? fifo_inst_r[rd_ptr_r] : {XLEN{1'b0}};
    assign bus.o_pc             = inst_valid_s ? fifo_pc_r[rd_ptr_r] : {XLEN{1'b0}};
    assign bus.o_fetch_fault    = (state_r == ST_FAULT);
    assign bus.o_fault_pc       = fault_pc_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a pipelined memory model and a PC
// scoreboard: every accepted request pushes its expected PC, every decode
// handshake pops and compares {instruction, PC}.
module tb_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN)) bus();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk (clk),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    mreq_t       memq[$];
    logic [31:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat = 1;
    int          exp_occ = 0;
    int          drop = 0;
    logic [31:0] exp_fpc = RESET_PC;
    bit          exp_fault = 1'b0;
    logic [31:0] exp_fault_pc = 32'h0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    bit          toggle_ready = 1'b0;
    int          accepts = 0;
    int          pops = 0;
    int          squashed = 0;
    int          first_acc_cyc = -1;
    int          first_val_cyc = -1;
    logic [31:0] first_acc_addr = 32'h0;
    bit          capture = 1'b0;
    logic [31:0] first_pop_pc = 32'h0;
    bit          saw_fffc = 1'b0;
    bit          wrapped = 1'b0;
    int          rel_cyc = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample at negedge, update model.
    task automatic cycle();
        bit          redir;
        bit          acc;
        bit          resp;
        bit          pop;
        bit          exp_valid;
        logic [31:0] pc;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.i_imem_resp_valid = 1'b1;
            bus.i_imem_resp_data  = memq[0].addr ^ MAGIC;
        end else begin
            bus.i_imem_resp_valid = 1'b0;
            bus.i_imem_resp_data  = 32'h0;
        end
        if (toggle_ready) bus.i_imem_req_ready = (cyc % 3 == 0);
        @(negedge clk);
        redir     = bus.i_redirect_valid;
        exp_valid = !exp_fault && !redir && (exp_occ + memq.size() < DEPTH);
        chk("req_valid", 32'(bus.o_imem_req_valid), 32'(exp_valid));
        if (bus.o_imem_req_valid) chk("req_addr", bus.o_imem_req_addr, exp_fpc);
        if (prev_stall && !redir) chk("stall_hold", bus.o_imem_req_addr, prev_addr);
        chk("inst_valid", 32'(bus.o_inst_valid), 32'(exp_occ != 0 && !exp_fault));
        chk("fetch_fault", 32'(bus.o_fetch_fault), 32'(exp_fault));
        chk("fault_pc", bus.o_fault_pc, exp_fault_pc);
        if (bus.o_inst_valid && first_val_cyc < 0) first_val_cyc = cyc;
        acc  = bus.o_imem_req_valid && bus.i_imem_req_ready;
        resp = bus.i_imem_resp_valid;
        pop  = bus.o_inst_valid && bus.i_inst_ready && !redir;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("pop_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                pc = exp_q.pop_front();
                chk("o_pc", bus.o_pc, pc);
                chk("o_inst", bus.o_inst, pc ^ MAGIC);
            end
            if (capture) begin
                first_pop_pc = bus.o_pc;
                capture = 1'b0;
            end
            if (saw_fffc && bus.o_pc == 32'h0) wrapped = 1'b1;
            if (bus.o_pc == 32'hFFFF_FFFC) saw_fffc = 1'b1;
            pops++;
            exp_occ--;
        end
        if (resp) begin
            void'(memq.pop_front());
            if (drop > 0) begin
                drop--;
                squashed++;
            end else if (redir) begin
                squashed++;
            end else begin
                exp_occ++;
            end
        end
        if (redir) begin
            drop = memq.size();
            exp_occ = 0;
            exp_q.delete();
            if (bus.i_redirect_pc[1:0] == 2'b00) begin
                exp_fpc   = bus.i_redirect_pc;
                exp_fault = 1'b0;
            end else begin
                exp_fault    = 1'b1;
                exp_fault_pc = bus.i_redirect_pc;
            end
        end
        if (acc) begin
            memq.push_back('{addr: bus.o_imem_req_addr, due: cyc + lat});
            exp_q.push_back(exp_fpc);
            if (first_acc_cyc < 0) begin
                first_acc_cyc  = cyc;
                first_acc_addr = bus.o_imem_req_addr;
            end
            exp_fpc = exp_fpc + 32'd4;
            accepts++;
        end
        prev_stall = bus.o_imem_req_valid && !bus.i_imem_req_ready;
        prev_addr  = bus.o_imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect(logic [31:0] target);
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = target;
        cycle();
        bus.i_redirect_valid = 1'b0;
    endtask

    // Asserts reset immediately (async), checks outputs, releases after 2 edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.o_imem_req_addr, RESET_PC);
        chk("rst_inst_valid", 32'(bus.o_inst_valid), 32'd0);
        chk("rst_inst", bus.o_inst, 32'h0);
        chk("rst_pc", bus.o_pc, 32'h0);
        chk("rst_fault", 32'(bus.o_fetch_fault), 32'd0);
        chk("rst_fault_pc", bus.o_fault_pc, 32'h0);
        memq.delete();
        exp_q.delete();
        exp_occ = 0;
        drop = 0;
        exp_fpc = RESET_PC;
        exp_fault = 1'b0;
        exp_fault_pc = 32'h0;
        prev_stall = 1'b0;
        bus.i_imem_resp_valid = 1'b0;
        bus.i_redirect_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel_cyc = cyc;
        first_acc_cyc = -1;
        first_val_cyc = -1;
    endtask

    initial begin
        bus.i_redirect_valid  = 1'b0;
        bus.i_redirect_pc     = 32'h0;
        bus.i_imem_req_ready  = 1'b1;
        bus.i_imem_resp_valid = 1'b0;
        bus.i_imem_resp_data  = 32'h0;
        bus.i_inst_ready      = 1'b1;
        #2;
        do_reset();

        // Streaming: 1-cycle memory, everything ready.
        lat = 1;
        run(12);
        chk("first_accept_cycle", 32'(first_acc_cyc), 32'(rel_cyc));
        chk("first_accept_addr", first_acc_addr, RESET_PC);
        chk("first_valid_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);

        // Decode stalled: credits cap issue at DEPTH, then drain in order.
        do_reset();
        bus.i_inst_ready = 1'b0;
        accepts = 0;
        run(10);
        chk("stall_accepts", 32'(accepts), 32'(DEPTH));
        chk("stall_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
        bus.i_inst_ready = 1'b1;
        pops = 0;
        run(10);
        chk("drain_progress", 32'(pops >= DEPTH), 32'd1);

        // Redirect with 3 outstanding requests on a 3-cycle memory.
        lat = 3;
        for (int i = 0; i < 20 && memq.size() != 3; i++) cycle();
        chk("outstanding_reached", 32'(memq.size()), 32'd3);
        squashed = 0;
        capture = 1'b1;
        redirect(32'h0000_0100);
        run(12);
        chk("squashed_count", 32'(squashed), 32'd3);
        chk("redirect_first_pc", first_pop_pc, 32'h0000_0100);

        // Misaligned target faults; a second misaligned target updates it.
        redirect(32'h0000_0102);
        chk("fault_set", 32'(bus.o_fetch_fault), 32'd1);
        chk("fault_pc_set", bus.o_fault_pc, 32'h0000_0102);
        accepts = 0;
        run(6);
        redirect(32'h0000_0106);
        chk("fault_pc_update", bus.o_fault_pc, 32'h0000_0106);
        run(3);
        chk("fault_no_accepts", 32'(accepts), 32'd0);
        capture = 1'b1;
        redirect(32'h0000_0200);
        chk("fault_clear", 32'(bus.o_fetch_fault), 32'd0);
        run(12);
        chk("resume_first_pc", first_pop_pc, 32'h0000_0200);

        // Request-ready toggling 1-in-3 across the address wrap.
        lat = 1;
        toggle_ready = 1'b1;
        saw_fffc = 1'b0;
        wrapped = 1'b0;
        redirect(32'hFFFF_FFF0);
        run(45);
        toggle_ready = 1'b0;
        bus.i_imem_req_ready = 1'b1;
        chk("pc_wrap", 32'(wrapped), 32'd1);

        // Async reset mid-burst with requests outstanding.
        lat = 3;
        for (int i = 0; i < 20 && memq.size() < 2; i++) cycle();
        chk("burst_outstanding", 32'(memq.size() >= 2), 32'd1);
        #3;
        do_reset();
        run(10);
        chk("restart_accept_addr", first_acc_addr, RESET_PC);
        chk("restart_accept_cycle", 32'(first_acc_cyc), 32'(rel_cyc));

        // Stop issuing and let everything drain out of the queue.
        bus.i_imem_req_ready = 1'b0;
        run(12);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule
